wave_render: RTL
================

# wave_render

Waveform rasteriser for the 640×480 @ 60 Hz display path. Sits directly upstream of the VGA timing/output stage: it stores one screen-width of 8-bit samples in a ping-pong buffer and turns the pixel coordinates the timing stage supplies into the 3-bit `rgb` value that stage drives out. Output is a vertically joined trace, with an optional graticule overlay.

## Interface
Parameters:
- `TRACE_RGB`, default 3'b010: trace colour (green).
- `GRID_RGB`, default 3'b001: graticule colour (blue).
- `Y_OFFSET`, default 367: screen row of sample value 0. Row = `Y_OFFSET` − sample, so 128 maps to row 239.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk`  in  1  pixel clock, 25.175 MHz nominal.
- `sys_rst`  in  1  synchronous active-high reset.
- `smp_valid`  in  1  write-side sample valid.
- `smp_data`  in  8  unsigned sample.
- `smp_ready`  out  1  write side can accept.
- `pix_x`  in  10  active-area column, 0..639.
- `pix_y`  in  10  active-area row, 0..479.
- `pix_de`  in  1  pixel inside visible area.
- `frame_start`  in  1  one-cycle pulse, first line of vertical blanking.
- `rgb`  out  3  pixel colour.
- `rgb_de`  out  1  `pix_de` delayed to align with `rgb`.
- `buf_swap`  out  1  one-cycle pulse when banks swap.

## Operation
- Two banks of 640×8: the write bank and the display bank. `wr_bank` selects between them. `disp_ok` flags that the display bank holds a full frame.
- Write side:
  - A transfer occurs when `smp_valid && smp_ready`.
  - Data goes to write bank address `wr_cnt`, then `wr_cnt` increments.
  - `smp_ready` = (`wr_cnt` < 640).
  - At `wr_cnt` == 640 the write bank is full and `smp_ready` is 0.
- Swap: on `frame_start` with registered `wr_cnt` == 640:
  - `wr_bank` toggles.
  - `wr_cnt` ← 0.
  - `disp_ok` ← 1.
  - `buf_swap` pulses.
- `frame_start` with the write bank not full: no swap. The old display bank is redrawn.
- A sample completing the fill in the same cycle as `frame_start` is written, but no swap happens that cycle. The swap waits for the next `frame_start`.
- Render, per pixel:
  - Compute r[x] = `Y_OFFSET` − s[x] in 10 bits (range 112..367).
  - Lit if `pix_y` lies in [min(r[x−1], r[x]), max(r[x−1], r[x])], inclusive.
  - For x = 0, use r[0] for both ends.
  - r[x−1] is the previous-column value held in a register. It is reloaded with r[0] when `pix_x` == 0.
- Colour priority:
  1. `pix_de` = 0 → 0.
  2. `disp_ok` = 0 → background only (grid if enabled, else 0).
  3. Trace lit → `TRACE_RGB`.
  4. Grid hit → `GRID_RGB`.
  5. Otherwise 3'b000.
- Reset values: `rgb` = 0, `rgb_de` = 0, `buf_swap` = 0, `smp_ready` = 1, `wr_cnt` = 0, `wr_bank` = 0, `disp_ok` = 0, previous-row register = 0.
- Reset mid-fill discards the partial bank. Reset mid-frame blanks output from the next cycle.

## Timing
- Render latency is fixed at 2 cycles from `pix_x`/`pix_y`/`pix_de` to `rgb`/`rgb_de`.
  - Cycle 0: synchronous RAM read at `pix_x`.
  - Cycle 1: data available, row computed, coordinates delayed.
  - Cycle 2: registered `rgb`.
- The downstream VGA stage delays its sync outputs by 2 cycles to match.
- `smp_ready` is registered-state combinational. It falls in the cycle after the 640th accept and rises in the cycle after the swap.
- `buf_swap` is asserted in the cycle after the `frame_start` sample.
- Writes and reads never target the same bank, so there is no read/write collision.

## Configuration
- `WAVE_GRID_EN` defined:
  - Graticule hit when `pix_x[5:0]` == 0, or `pix_x` == 639, or `pix_y` ∈ {0, 60, 120, …, 420, 479}.
  - This gives 10×8 divisions.
- `WAVE_GRID_EN` undefined: no grid logic. The grid hit is constant 0, and the background is 3'b000.

## Structure
- Package `wave_pkg`:
  - `H_ACTIVE` = 640, `V_ACTIVE` = 480.
  - `GRID_DX` = 64, `GRID_DY` = 60.
  - Colour constants.
  - Sample typedef (8-bit unsigned).
- Sub-module `wave_ram`: simple dual-port 1280×8 memory.
  - Bank bit is the address MSB.
  - One synchronous write port and one synchronous read port.
  - Infers block RAM.

## Test plan
- After reset, drive active-area pixels → `rgb` = 0 (or grid colour under `WAVE_GRID_EN`), `smp_ready` = 1, `buf_swap` = 0.
- Write 640 samples of 128, then pulse `frame_start` → `smp_ready` low after the 640th accept, `buf_swap` pulse. Next frame: `rgb` = 3'b010 only at row 239, all columns, 2 cycles after the coordinates.
- Write ramp s[x] = x mod 256, swap, render → column 1 lit at rows 366..367, column 0 only at row 367, column 255 at rows 112..113.
- Write 639 samples, pulse `frame_start` → no `buf_swap`, old image retained. Write the 640th sample, then pulse `frame_start` → swap.
- Complete the 640th write in the same cycle as `frame_start` → no swap. Swap occurs at the following `frame_start`.
- Assert `sys_rst` mid-frame and mid-fill → next cycle `rgb` = 0, `rgb_de` = 0, `wr_cnt` = 0, `smp_ready` = 1, `disp_ok` = 0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared constants, sample type and graticule helper for the waveform rasteriser.
// The graticule helper is only referenced when WAVE_GRID_EN is defined.
package wave_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int GRID_DX  = 64;
    localparam int GRID_DY  = 60;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_BLUE  = 3'b001;

    typedef logic [7:0] sample_t;

    // Graticule: vertical lines every GRID_DX plus the right edge, horizontal
    // lines every GRID_DY plus the bottom edge (10 x 8 divisions).
    function automatic logic grid_hit(input logic [9:0] x, input logic [9:0] y);
        logic hit;
        hit = (x[5:0] == 6'd0) || (x == 10'(H_ACTIVE - 1)) || (y == 10'(V_ACTIVE - 1));
        for (int k = 0; k < 8; k++) begin
            if (y == 10'(k * GRID_DY)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/wave_ram.sv
// Simple dual-port 1280x8 sample store: address MSB selects the bank, the low
// ten bits the column. One synchronous write port, one synchronous read port.
module wave_ram
    import wave_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  sample_t     wr_data,
    input  logic [10:0] rd_addr,
    output sample_t     rd_data
);

    sample_t mem [0:1279];

    function automatic logic [10:0] bank_index(input logic [10:0] a);
        return a[10] ? (11'd640 + {1'b0, a[9:0]}) : {1'b0, a[9:0]};
    endfunction

    // Unreset storage and read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bank_index(wr_addr)] <= wr_data;
        end
        rd_data <= mem[bank_index(rd_addr)];
    end

endmodule

// File: rtl/wave_render.sv
// Ping-pong buffered waveform rasteriser: fills one bank from the sample stream
// while drawing a vertically joined trace from the other. Graticule overlay is
// compiled in when the macro WAVE_GRID_EN is defined.
module wave_render
    import wave_pkg::*;
#(
    parameter logic [2:0] TRACE_RGB = RGB_GREEN,
    parameter logic [2:0] GRID_RGB  = RGB_BLUE,
    parameter int         Y_OFFSET  = 367
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       smp_valid,
    input  logic [7:0] smp_data,
    output logic       smp_ready,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_de,
    input  logic       frame_start,
    output logic [2:0] rgb,
    output logic       rgb_de,
    output logic       buf_swap
);

    localparam logic [9:0] WR_FULL = 10'(H_ACTIVE);

    logic [9:0] wr_cnt_q, wr_cnt_d;
    logic       wr_bank_q, wr_bank_d;
    logic       disp_ok_q, disp_ok_d;
    logic       buf_swap_q, buf_swap_d;
    logic       de1_q, de1_d;
    logic [9:0] x1_q, x1_d;
    logic [9:0] y1_q, y1_d;
    logic [9:0] prev_r_q, prev_r_d;
    logic [2:0] rgb_q, rgb_d;
    logic       rgb_de_q, rgb_de_d;

    logic       wr_accept;
    logic       swap;
    sample_t    ram_rd;
    logic [9:0] r_cur, r_prev, r_lo, r_hi;
    logic       lit, grid_s;
    logic [2:0] bg_rgb;

    assign smp_ready = (wr_cnt_q < WR_FULL);
    assign wr_accept = smp_valid && smp_ready;
    // Only a bank that was already full before this cycle may be swapped.
    assign swap      = frame_start && (wr_cnt_q == WR_FULL);

    wave_ram u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_accept),
        .wr_addr ({wr_bank_q, wr_cnt_q}),
        .wr_data (smp_data),
        .rd_addr ({~wr_bank_q, pix_x}),
        .rd_data (ram_rd)
    );

    // Write-side bookkeeping and bank swap.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        disp_ok_d  = disp_ok_q;
        buf_swap_d = swap;
        if (swap) begin
            wr_bank_d = ~wr_bank_q;
            wr_cnt_d  = 10'd0;
            disp_ok_d = 1'b1;
        end else if (wr_accept) begin
            wr_cnt_d = wr_cnt_q + 10'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

`ifdef WAVE_GRID_EN
    assign grid_s = grid_hit(x1_q, y1_q);
`else
    assign grid_s = 1'b0;
`endif

    // Stage 1: trace span between this column's row and the previous column's.
    always_comb begin
        r_cur  = 10'(Y_OFFSET) - {2'b00, ram_rd};
        r_prev = (x1_q == 10'd0) ? r_cur : prev_r_q;
        if (r_prev < r_cur) begin
            r_lo = r_prev;
            r_hi = r_cur;
        end else begin
            r_lo = r_cur;
            r_hi = r_prev;
        end
        lit      = (y1_q >= r_lo) && (y1_q <= r_hi);
        bg_rgb   = grid_s ? GRID_RGB : RGB_BLACK;
        prev_r_d = de1_q ? r_cur : prev_r_q;
        de1_d    = pix_de;
        x1_d     = pix_x;
        y1_d     = pix_y;
        rgb_de_d = de1_q;
        if (!de1_q) begin
            rgb_d = RGB_BLACK;
        end else if (!disp_ok_q) begin
            rgb_d = bg_rgb;
        end else if (lit) begin
            rgb_d = TRACE_RGB;
        end else if (grid_s) begin
            rgb_d = GRID_RGB;
        end else begin
            rgb_d = RGB_BLACK;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_cnt_q   <= 10'd0;
            wr_bank_q  <= 1'b0;
            disp_ok_q  <= 1'b0;
            buf_swap_q <= 1'b0;
            de1_q      <= 1'b0;
            x1_q       <= 10'd0;
            y1_q       <= 10'd0;
            prev_r_q   <= 10'd0;
            rgb_q      <= 3'b000;
            rgb_de_q   <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            disp_ok_q  <= disp_ok_d;
            buf_swap_q <= buf_swap_d;
            de1_q      <= de1_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            prev_r_q   <= prev_r_d;
            rgb_q      <= rgb_d;
            rgb_de_q   <= rgb_de_d;
        end
    end

    assign rgb      = rgb_q;
    assign rgb_de   = rgb_de_q;
    assign buf_swap = buf_swap_q;

endmodule
